// File: rtl/buscaminas_pkg.sv
// Shared constants, cell layout, FSM encoding and board helpers for the minesweeper game sequencer.
package buscaminas_pkg;

  localparam int N         = 8;
  localparam int CELLS     = N * N;
  localparam int MAX_BOMBS = 40;

  // Cell word: [8] bomb, [7] revealed, [6] flagged, [5:2] neighbour count, [1:0] zero.
  localparam int B_BOMB   = 8;
  localparam int B_REV    = 7;
  localparam int B_FLAG   = 6;
  localparam int B_CNT_HI = 5;
  localparam int B_CNT_LO = 2;

  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: feedback = q7^q5^q4^q3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLACE = 3'd1,
    S_COUNT = 3'd2,
    S_PLAY  = 3'd3,
    S_SWEEP = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6
  } estado_t;

  // Number of set bits of mask among the in-board 8-neighbours of idx.
  function automatic logic [3:0] neigh_sum(input logic [CELLS-1:0] mask, input logic [5:0] idx);
    logic [3:0] s;
    int r, c, rr, cc;
    s = 4'd0;
    r = int'(idx[5:3]);
    c = int'(idx[2:0]);
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < N && cc >= 0 && cc < N)
          s = s + 4'(mask[rr*N + cc]);
      end
    end
    return s;
  endfunction

  function automatic logic [5:0] clamp_k(input logic [5:0] req);
    if (req == 6'd0) return 6'd1;
    if (int'(req) > MAX_BOMBS) return 6'(MAX_BOMBS);
    return req;
  endfunction

endpackage

// File: rtl/controlador_juego_if.sv
// Front-end / display bundle of the game sequencer: button pulses in, board read port and status out.
interface controlador_juego_if;

  // Handshake: start and btn_* are single-cycle pulses sampled on the rising edge (no ready;
  // pulses the controller cannot act on are dropped). rd_cell is the cell at rd_idx one cycle later.
  logic [5:0] entrada_bombas;
  logic       start;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_reveal;
  logic       btn_flag;
  logic [5:0] rd_idx;
  logic [8:0] rd_cell;
  logic [2:0] cursor_row;
  logic [2:0] cursor_col;
  logic [2:0] estado;
  logic       busy;
  logic       win;
  logic       lose;
  logic [6:0] revealed_cnt;

  modport master (
    output entrada_bombas, start, btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag, rd_idx,
    input  rd_cell, cursor_row, cursor_col, estado, busy, win, lose, revealed_cnt
  );

  modport slave (
    input  entrada_bombas, start, btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag, rd_idx,
    output rd_cell, cursor_row, cursor_col, estado, busy, win, lose, revealed_cnt
  );

endinterface

// File: rtl/controlador_juego_lfsr8.sv
// Free-running 8-bit LFSR; only the low six bits are consumed, as a board index candidate.
module lfsr8
  import buscaminas_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] idx
);

  logic [7:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[6:0], ^(q & LFSR_TAPS)};
  end

  assign idx = q[5:0];

endmodule

// File: rtl/controlador_juego.sv
// Minesweeper game sequencer: bomb placement, counting, play, flood reveal, win/lose.
// Build option: define SAFE_START_EN to keep bombs off cells 0, 1, 8 and 9.
module controlador_juego
  import buscaminas_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  controlador_juego_if.slave  bus
);

  estado_t                   state, state_n;
  logic [CELLS-1:0][8:0]     board, board_n;
  logic [5:0]                k, k_n, placed, placed_n, scan, scan_n;
  logic                      changed, changed_n, pasada, pasada_n;
  logic [2:0]                row, row_n, col, col_n;
  logic [6:0]                rcnt, rcnt_n, win_target;
  logic                      win_r, win_n, lose_r, lose_n;
  logic [8:0]                rd_cell_r, cur, scell;
  logic [5:0]                cand, cidx;
  logic                      cand_ok, grow;
  logic [CELLS-1:0]          bombs, zero_open;

  lfsr8 u_lfsr (.clk(clk), .reset(reset), .idx(cand));

`ifdef SAFE_START_EN
  assign cand_ok = !(cand == 6'd0 || cand == 6'd1 || cand == 6'd8 || cand == 6'd9);
`else
  assign cand_ok = 1'b1;
`endif

  always_comb begin
    bombs     = '0;
    zero_open = '0;
    for (int i = 0; i < CELLS; i++) begin
      bombs[i]     = board[i][B_BOMB];
      zero_open[i] = board[i][B_REV] && !board[i][B_BOMB] && (board[i][B_CNT_HI:B_CNT_LO] == 4'd0);
    end
  end

  assign cidx       = {row, col};
  assign cur        = board[cidx];
  assign scell      = board[scan];
  assign win_target = 7'(CELLS) - {1'b0, k};
  // A sweep opens a cell when any revealed zero cell touches it.
  assign grow       = !scell[B_REV] && !scell[B_FLAG] && !scell[B_BOMB] &&
                      (neigh_sum(zero_open, scan) != 4'd0);

  always_comb begin
    state_n   = state;
    board_n   = board;
    k_n       = k;
    placed_n  = placed;
    scan_n    = scan;
    changed_n = changed;
    pasada_n  = pasada;
    row_n     = row;
    col_n     = col;
    rcnt_n    = rcnt;
    win_n     = win_r;
    lose_n    = lose_r;
    if (bus.start) begin
      board_n  = '0;
      row_n    = 3'd0;
      col_n    = 3'd0;
      win_n    = 1'b0;
      lose_n   = 1'b0;
      rcnt_n   = 7'd0;
      k_n      = clamp_k(bus.entrada_bombas);
      placed_n = 6'd0;
      scan_n   = 6'd0;
      state_n  = S_PLACE;
    end else begin
      unique case (state)
        S_PLACE: begin
          if (cand_ok && !board[cand][B_BOMB]) begin
            board_n[cand][B_BOMB] = 1'b1;
            placed_n = placed + 6'd1;
            if (placed_n == k) begin
              scan_n  = 6'd0;
              state_n = S_COUNT;
            end
          end
        end
        S_COUNT: begin
          board_n[scan][B_CNT_HI:B_CNT_LO] = neigh_sum(bombs, scan);
          scan_n = scan + 6'd1;
          if (scan == 6'(CELLS-1)) state_n = S_PLAY;
        end
        S_PLAY: begin
          if (bus.btn_reveal) begin
            if (!cur[B_FLAG] && !cur[B_REV]) begin
              if (cur[B_BOMB]) begin
                for (int i = 0; i < CELLS; i++)
                  if (bombs[i]) board_n[i][B_REV] = 1'b1;
                lose_n  = 1'b1;
                state_n = S_LOSE;
              end else begin
                board_n[cidx][B_REV] = 1'b1;
                rcnt_n = rcnt + 7'd1;
                if (cur[B_CNT_HI:B_CNT_LO] == 4'd0) begin
                  scan_n    = 6'd0;
                  changed_n = 1'b0;
                  pasada_n  = 1'b0;
                  state_n   = S_SWEEP;
                end else if (rcnt_n == win_target) begin
                  win_n   = 1'b1;
                  state_n = S_WIN;
                end
              end
            end
          end else if (bus.btn_flag) begin
            if (!cur[B_REV]) board_n[cidx][B_FLAG] = !cur[B_FLAG];
          end else if (bus.btn_up) begin
            if (row != 3'd0) row_n = row - 3'd1;
          end else if (bus.btn_down) begin
            if (row != 3'(N-1)) row_n = row + 3'd1;
          end else if (bus.btn_left) begin
            if (col != 3'd0) col_n = col - 3'd1;
          end else if (bus.btn_right) begin
            if (col != 3'(N-1)) col_n = col + 3'd1;
          end
        end
        S_SWEEP: begin
          if (grow) begin
            board_n[scan][B_REV] = 1'b1;
            rcnt_n = rcnt + 7'd1;
          end
          changed_n = changed | grow;
          scan_n    = scan + 6'd1;
          // End of a pass; a second pass is always made so late openings propagate.
          if (scan == 6'(CELLS-1)) begin
            changed_n = 1'b0;
            pasada_n  = 1'b1;
            if (pasada && !(changed | grow)) begin
              if (rcnt_n == win_target) begin
                win_n   = 1'b1;
                state_n = S_WIN;
              end else begin
                state_n = S_PLAY;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      board     <= '0;
      k         <= 6'd1;
      placed    <= 6'd0;
      scan      <= 6'd0;
      changed   <= 1'b0;
      pasada    <= 1'b0;
      row       <= 3'd0;
      col       <= 3'd0;
      rcnt      <= 7'd0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
      rd_cell_r <= 9'd0;
    end else begin
      state     <= state_n;
      board     <= board_n;
      k         <= k_n;
      placed    <= placed_n;
      scan      <= scan_n;
      changed   <= changed_n;
      pasada    <= pasada_n;
      row       <= row_n;
      col       <= col_n;
      rcnt      <= rcnt_n;
      win_r     <= win_n;
      lose_r    <= lose_n;
      rd_cell_r <= board_n[bus.rd_idx];
    end
  end

  assign bus.rd_cell      = rd_cell_r;
  assign bus.cursor_row   = row;
  assign bus.cursor_col   = col;
  assign bus.estado       = state;
  assign bus.busy         = (state == S_PLACE) || (state == S_COUNT) || (state == S_SWEEP);
  assign bus.win          = win_r;
  assign bus.lose         = lose_r;
  assign bus.revealed_cnt = rcnt;

endmodule
